// File: rtl/digit_scan.sv
// Eight-digit multiplexed seven-segment scanner with a three-register bus slave.
// Each digit owns a (D+1)-cycle slot whose first cycle is blanked as dead time.
module digit_scan #(
  parameter logic [15:0] DIV_DEFAULT = 16'd49999,
  parameter logic [31:0] BASE_ADDR   = 32'hfffffc10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        en,
  input  logic [3:0]  byte_sel,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic [31:0] data_out,
  output logic [7:0]  sel_out,
  output logic [7:0]  digital_out
);

  logic [31:0] data_q, data_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;

  logic        hitData, hitCtrl, hitDiv;
  logic [15:0] effDiv;
  logic [3:0]  digitVal;

  assign hitData = (addr == BASE_ADDR);
  assign hitCtrl = (addr == BASE_ADDR + 32'd4);
  assign hitDiv  = (addr == BASE_ADDR + 32'd8);

  function automatic logic [6:0] hexSeg(input logic [3:0] v);
    case (v)
      4'h0: hexSeg = 7'h40;
      4'h1: hexSeg = 7'h79;
      4'h2: hexSeg = 7'h24;
      4'h3: hexSeg = 7'h30;
      4'h4: hexSeg = 7'h19;
      4'h5: hexSeg = 7'h12;
      4'h6: hexSeg = 7'h02;
      4'h7: hexSeg = 7'h78;
      4'h8: hexSeg = 7'h00;
      4'h9: hexSeg = 7'h10;
      4'ha: hexSeg = 7'h08;
      4'hb: hexSeg = 7'h03;
      4'hc: hexSeg = 7'h46;
      4'hd: hexSeg = 7'h21;
      4'he: hexSeg = 7'h06;
      default: hexSeg = 7'h0e;
    endcase
  endfunction

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    div_d  = div_q;
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_sel[i] && hitData) data_d[8*i +: 8] = data_in[8*i +: 8];
      end
      for (int i = 0; i < 2; i++) begin
        if (byte_sel[i] && hitCtrl) ctrl_d[8*i +: 8] = data_in[8*i +: 8];
        if (byte_sel[i] && hitDiv)  div_d[8*i +: 8]  = data_in[8*i +: 8];
      end
    end
  end

  // A >= compare (not ==) lets a lowered divider take effect on the very next edge.
  always_comb begin
    effDiv = (div_q == 16'd0) ? 16'd1 : div_q;
    cnt_d  = cnt_q + 16'd1;
    idx_d  = idx_q;
    if (cnt_q >= effDiv) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 3'd1;
    end
  end

  always_comb begin
    digitVal = data_q[4*idx_q +: 4];
    sel_d    = 8'hff;
    if (cnt_q != 16'd0 && ctrl_q[idx_q]) sel_d = ~(8'b1 << idx_q);
    seg_d    = {~ctrl_q[{1'b1, idx_q}], hexSeg(digitVal)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= 32'h0;
      ctrl_q <= 16'h0;
      div_q  <= DIV_DEFAULT;
      cnt_q  <= 16'h0;
      idx_q  <= 3'd0;
      sel_q  <= 8'hff;
      seg_q  <= 8'hff;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
    end
  end

  always_comb begin
    data_out = 32'h0;
    if (rst && en && !we) begin
      if (hitData)      data_out = data_q;
      else if (hitCtrl) data_out = {16'h0, ctrl_q};
      else if (hitDiv)  data_out = {16'h0, div_q};
    end
  end

  assign sel_out     = sel_q;
  assign digital_out = seg_q;

endmodule

// File: doc/digit_scan.md
DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 SHALL have parameter DIV_DEFAULT, default 16'd49999, reset value of the scan divider register.
REQ-002 SHALL have parameter BASE_ADDR, default 32'hfffffc10, base of the three-register block.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port addr  input  32  bus address.
REQ-006 SHALL have port en  input  1  bus access enable, active-high.
REQ-007 SHALL have port byte_sel  input  4  write byte lanes; bit i enables data_in[8i+7:8i].
REQ-008 SHALL have port data_in  input  32  write data from CPU.
REQ-009 SHALL have port we  input  1  write enable, active-high.
REQ-010 SHALL have port data_out  output  32  read data to arbiter, combinational.
REQ-011 SHALL have port sel_out  output  8  digit select to display, active-low, registered.
REQ-012 SHALL have port digital_out  output  8  segments {DP,G,F,E,D,C,B,A} to display, active-low, registered.

Function
REQ-013 SHALL decode DATA at BASE_ADDR+0: 8 nibbles; digit i value = DATA[4i+3:4i].
REQ-014 SHALL decode CTRL at BASE_ADDR+4: [7:0] digit enable mask, [15:8] decimal-point mask, [31:16] read as 0.
REQ-015 SHALL decode DIV at BASE_ADDR+8: [15:0] slot length minus one, [31:16] read as 0.
REQ-016 SHALL write a register on a rising edge when addr matches, en=1 and we=1, updating only lanes with byte_sel bit set.
REQ-017 SHALL ignore writes to unmatched addresses and to unimplemented bits.
REQ-018 SHALL drive data_out with the matched register value when en=1 and we=0, else 32'h0.
REQ-019 SHALL run a 16-bit slot counter cnt and a 3-bit digit index idx.
REQ-020 SHALL use effective divider D = max(DIV,1).
REQ-021 SHALL, when cnt >= D, set cnt to 0 and set idx to idx+1 mod 8 (7 wraps to 0); else cnt increments.
REQ-022 SHALL, when DIV is lowered below the current cnt, wrap on the next edge via the >= compare, with no stall.
REQ-023 SHALL register sel_out = 8'hff (dead time) when cnt==0 or CTRL[idx]==0.
REQ-024 SHALL otherwise register sel_out = ~(8'b1 << idx).
REQ-025 SHALL register digital_out[6:0] = active-low hex pattern of digit idx and digital_out[7] = ~CTRL[8+idx].
REQ-026 SHALL use hex patterns {0:C0,1:F9,2:A4,3:B0,4:99,5:92,6:82,7:F8,8:80,9:90,A:88,b:83,C:C6,d:A1,E:86,F:8E} (bit7 shown as 1).
REQ-027 SHALL drive registered outputs from the cnt/idx/register state of the previous cycle, giving one cycle of latency.
REQ-028 SHALL, on a write coinciding with a scan edge, use the pre-write register value on that edge and the new value from the next edge.
REQ-029 SHALL give a disabled digit its full slot time, so lit-digit brightness is independent of the mask.

Reset
REQ-030 SHALL, while rst=0, immediately force DATA=0, CTRL=0, DIV=DIV_DEFAULT, cnt=0, idx=0, sel_out=8'hff, digital_out=8'hff.
REQ-031 SHALL drive data_out=0 while rst=0.
REQ-032 SHALL, on rst asserted mid-scan, take reset values within the same cycle with no clock edge needed.
REQ-033 SHALL, after rst deasserts, start scanning at idx=0, cnt=0.

Verification
REQ-034 SHALL verify: reset, then write DIV=3, CTRL=0x00FF, DATA=0x76543210 -> per 4-cycle slot, sel_out is ff for 1 cycle then fe/C0 for 3 cycles, then fd/F9 ... 7f/F8, then back to fe.
REQ-035 SHALL verify: CTRL=0x0105, DIV=3 -> only digits 0 and 2 lit; digit 0 shows digital_out=0x40 (DP on); slots for digits 1 and 3-7 are all ff.
REQ-036 SHALL verify: byte_sel=4'b0010 write of 0xAABBCCDD to DATA=0 -> DATA reads 0x0000CC00; an unmatched addr write changes nothing.
REQ-037 SHALL verify: DIV=0 -> behaves as D=1, alternating ff dead cycle and digit cycle, with idx advancing every 2 cycles.
REQ-038 SHALL verify: DIV=100, cnt=50, write DIV=10 -> wrap on next edge and idx increments.
REQ-039 SHALL verify: rst pulsed low between clock edges mid-scan -> outputs ff and registers at reset values immediately; a read of DIV returns DIV_DEFAULT.
